// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts one byte per AXI-Stream handshake and serialises
// it as start / data (LSB first) / optional parity / one or two stop bits on TXD.
module uart_tx_sequencer #(
    parameter int DATA_BITS = 8
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [7:0]  S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [15:0] PR_DIV,
    input  logic        STOP_BITS,
    input  logic [2:0]  PARITY,
    input  logic        TX_EN,
    output logic        TXD,
    output logic        TXB,
    output logic        FRAME_DONE,
    output logic [2:0]  dbg_state
);

    // Handshake: a byte is transferred on a rising ACLK edge where both
    // S_AXIS_TVALID and S_AXIS_TREADY are high; TREADY never depends on TVALID.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_e;

    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    state_e      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] div_q, div_d;
    logic        stop_q, stop_d;
    logic [2:0]  par_mode_q, par_mode_d;
    logic        txd_q, txd_d;
    logic        txb_q, txb_d;
    logic        done_q, done_d;

    logic        accept;
    logic        cnt_end;
    logic        par_en;

    function automatic logic parity_bit(input logic [7:0] d, input logic [2:0] mode);
        case (mode)
            3'b001:  parity_bit = ~^d;
            3'b010:  parity_bit = ^d;
            3'b011:  parity_bit = 1'b1;
            default: parity_bit = 1'b0;
        endcase
    endfunction

    assign S_AXIS_TREADY = (state_q == IDLE) && TX_EN && !ARESET;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    // 17-bit compare keeps PR_DIV = 0xFFFF free of any wrap at the bit boundary.
    assign cnt_end       = (cnt_q == {1'b0, div_q});
    assign par_en        = (par_mode_q >= 3'b001) && (par_mode_q <= 3'b100);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        div_d      = div_q;
        stop_d     = stop_q;
        par_mode_d = par_mode_q;

        if (state_q == IDLE) begin
            if (accept) begin
                state_d    = START;
                cnt_d      = 17'd0;
                bit_d      = 3'd0;
                data_d     = S_AXIS_TDATA & DATA_MASK;
                div_d      = PR_DIV;
                stop_d     = STOP_BITS;
                par_mode_d = PARITY;
            end
        end else if (!cnt_end) begin
            cnt_d = cnt_q + 17'd1;
        end else begin
            cnt_d = 17'd0;
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
                DATA: begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = 3'd0;
                        state_d = par_en ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                PAR: begin
                    state_d = STOP;
                    bit_d   = 3'd0;
                end
                STOP: begin
                    if (bit_q[0] == stop_q) begin
                        state_d = IDLE;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    bit_d   = 3'd0;
                end
            endcase
        end

        // Outputs are registered from the next-state values so they align with state_q.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_d[bit_d];
            PAR:     txd_d = parity_bit(data_d, par_mode_d);
            default: txd_d = 1'b1;
        endcase
        txb_d  = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == {1'b0, div_d}) && (bit_d[0] == stop_d);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            cnt_q      <= 17'd0;
            bit_q      <= 3'd0;
            data_q     <= 8'd0;
            div_q      <= 16'd0;
            stop_q     <= 1'b0;
            par_mode_q <= 3'd0;
            txd_q      <= 1'b1;
            txb_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            div_q      <= div_d;
            stop_q     <= stop_d;
            par_mode_q <= par_mode_d;
            txd_q      <= txd_d;
            txb_q      <= txb_d;
            done_q     <= done_d;
        end
    end

    assign TXD        = txd_q;
    assign TXB        = txb_q;
    assign FRAME_DONE = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: table of frames checked cycle by cycle against a
// waveform model, plus hand-written reset, back-to-back and mid-frame sequences.
module tb_uart_tx_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [7:0]  S_AXIS_TDATA = 8'd0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic [15:0] PR_DIV = 16'd0;
    logic        STOP_BITS = 1'b0;
    logic [2:0]  PARITY = 3'd0;
    logic        TX_EN = 1'b1;
    logic        TXD;
    logic        TXB;
    logic        FRAME_DONE;
    logic [2:0]  dbg_state;

    uart_tx_sequencer #(.DATA_BITS(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY), .PR_DIV(PR_DIV), .STOP_BITS(STOP_BITS),
        .PARITY(PARITY), .TX_EN(TX_EN), .TXD(TXD), .TXB(TXB),
        .FRAME_DONE(FRAME_DONE), .dbg_state(dbg_state)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        stop;
        logic [2:0]  par;
        int          exp_cycles;
    } vec_t;

    // Each entry is {TXD, TXB, FRAME_DONE} for one cycle.
    logic [2:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input logic [7:0] d, input int div, input logic stop,
                              input logic [2:0] par);
        logic bq[$];
        bq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bq.push_back(d[i]);
        case (par)
            3'd1: bq.push_back(~^d);
            3'd2: bq.push_back(^d);
            3'd3: bq.push_back(1'b1);
            3'd4: bq.push_back(1'b0);
            default: ;
        endcase
        bq.push_back(1'b1);
        if (stop) bq.push_back(1'b1);
        for (int b = 0; b < bq.size(); b++)
            for (int c = 0; c <= div; c++)
                exp_q.push_back({bq[b], 1'b1, (b == bq.size() - 1) && (c == div)});
    endtask

    task automatic wait_ready(input string name);
        int w = 0;
        while (!S_AXIS_TREADY && w < 50) begin
            @(negedge ACLK);
            w++;
        end
        if (w >= 50) check({name, "_ready_timeout"}, 32'(S_AXIS_TREADY), 32'd1);
    endtask

    // mode 0: plain frame; mode 1: change config and drop TX_EN mid-frame;
    // mode 2: pulse ARESET in the third data bit (PR_DIV = 3 assumed).
    task automatic run_frame(input string name, input logic [7:0] d, input logic [15:0] div,
                             input logic stop, input logic [2:0] par, input int exp_cycles,
                             input int mode);
        int k = 0;
        int txb_cnt = 0;
        logic [2:0] e;
        @(negedge ACLK);
        S_AXIS_TDATA = d; PR_DIV = div; STOP_BITS = stop; PARITY = par;
        S_AXIS_TVALID = 1'b1;
        #1;
        wait_ready(name);
        push_frame(d, int'(div), stop, par);
        while (exp_q.size() > 0) begin
            @(negedge ACLK);
            k++;
            if (k == 1) S_AXIS_TVALID = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("%s_cyc%0d", name, k), {29'd0, TXD, TXB, FRAME_DONE}, {29'd0, e});
            txb_cnt += int'(TXB);
            if (mode == 1 && k == 10) begin
                PR_DIV = 16'd7; PARITY = 3'b010; STOP_BITS = 1'b1; TX_EN = 1'b0;
                S_AXIS_TDATA = 8'hAA; S_AXIS_TVALID = 1'b1;
            end
            if (mode == 2 && k == 14) begin
                ARESET = 1'b1;
                exp_q.delete();
            end
        end
        if (mode == 2) begin
            @(negedge ACLK);
            check({name, "_abort_out"}, {29'd0, TXD, TXB, FRAME_DONE}, 32'b100);
            check({name, "_abort_ready"}, 32'(S_AXIS_TREADY), 32'd0);
            ARESET = 1'b0;
            txb_cnt = 0;
            for (int i = 0; i < 45; i++) begin
                @(negedge ACLK);
                txb_cnt += int'(TXB) + int'(FRAME_DONE) + int'(!TXD);
            end
            check({name, "_abort_quiet"}, 32'(txb_cnt), 32'd0);
        end else begin
            check({name, "_len"}, 32'(txb_cnt), 32'(exp_cycles));
            @(negedge ACLK);
            check({name, "_idle"}, {29'd0, TXD, TXB, FRAME_DONE}, 32'b100);
            check({name, "_ready_after"}, 32'(S_AXIS_TREADY), 32'(TX_EN));
        end
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        logic [2:0] e;

        vecs[0] = '{8'h55, 16'd3, 1'b0, 3'd0, 40};
        vecs[1] = '{8'h07, 16'd1, 1'b0, 3'd2, 22};
        vecs[2] = '{8'h07, 16'd1, 1'b0, 3'd1, 22};
        vecs[3] = '{8'hA0, 16'd0, 1'b1, 3'd3, 12};
        vecs[4] = '{8'h3C, 16'd2, 1'b0, 3'd4, 33};
        vecs[5] = '{8'hFF, 16'd0, 1'b0, 3'd5, 10};
        vecs[6] = '{8'h81, 16'd0, 1'b1, 3'd7, 11};
        vecs[7] = '{8'($urandom_range(0, 255)), 16'd1, 1'b0, 3'd2, 22};

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_out", {29'd0, TXD, TXB, FRAME_DONE}, 32'b100);
        check("rst_ready", 32'(S_AXIS_TREADY), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        ARESET = 1'b0;
        #1;
        check("rst_release_ready", 32'(S_AXIS_TREADY), 32'd1);

        // Idle with TVALID low
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            n += int'(!TXD) + int'(TXB) + int'(!S_AXIS_TREADY);
        end
        check("idle_hold", 32'(n), 32'd0);

        for (int v = 0; v < 8; v++)
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].div, vecs[v].stop,
                      vecs[v].par, vecs[v].exp_cycles, 0);

        // Back-to-back with TVALID held high
        @(negedge ACLK);
        S_AXIS_TDATA = 8'h01; PR_DIV = 16'd0; STOP_BITS = 1'b0; PARITY = 3'd0;
        S_AXIS_TVALID = 1'b1;
        #1;
        wait_ready("b2b");
        push_frame(8'h01, 0, 1'b0, 3'd0);
        exp_q.push_back(3'b100);
        push_frame(8'h02, 0, 1'b0, 3'd0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge ACLK);
            if (k == 0) S_AXIS_TDATA = 8'h02;
            if (k == 10) check("b2b_gap_ready", 32'(S_AXIS_TREADY), 32'd1);
            if (k == 11) S_AXIS_TVALID = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("b2b_cyc%0d", k + 1), {29'd0, TXD, TXB, FRAME_DONE}, {29'd0, e});
        end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            n += int'(TXB);
        end
        check("b2b_once", 32'(n), 32'd0);

        // Reset in third data bit, then a clean frame
        run_frame("rst_mid", 8'h55, 16'd3, 1'b0, 3'd0, 40, 2);
        run_frame("post_rst", 8'h55, 16'd3, 1'b0, 3'd0, 40, 0);

        // Config change and TX_EN drop mid-frame
        run_frame("cfg_mid", 8'h55, 16'd3, 1'b0, 3'd0, 40, 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            n += int'(TXB) + int'(S_AXIS_TREADY);
        end
        check("txen_block", 32'(n), 32'd0);
        S_AXIS_TVALID = 1'b0;
        TX_EN = 1'b1;
        #1;
        check("txen_return_ready", 32'(S_AXIS_TREADY), 32'd1);

        // Maximum divider: start bit must last 65536 cycles
        @(negedge ACLK);
        S_AXIS_TDATA = 8'h01; PR_DIV = 16'hFFFF; STOP_BITS = 1'b0; PARITY = 3'd0;
        S_AXIS_TVALID = 1'b1;
        #1;
        wait_ready("maxdiv");
        @(negedge ACLK);
        S_AXIS_TVALID = 1'b0;
        n = 0;
        while (TXD == 1'b0 && n < 70000) begin
            n++;
            @(negedge ACLK);
        end
        check("maxdiv_start_len", 32'(n), 32'd65536);
        check("maxdiv_bit0", {31'd0, TXD}, 32'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check("maxdiv_abort", {29'd0, TXD, TXB, FRAME_DONE}, 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..8.
REQ-002 ACLK  input  1  sole clock; all logic SHALL be clocked on the rising edge.
REQ-003 ARESET  input  1  reset, synchronous and active-high.
REQ-004 S_AXIS_TDATA  input  8  byte to transmit; bits [DATA_BITS-1:0] used, upper bits ignored.
REQ-005 S_AXIS_TVALID  input  1  source has a byte.
REQ-006 S_AXIS_TREADY  output  1  sequencer accepts a byte this cycle.
REQ-007 PR_DIV  input  16  bit period minus one, in ACLK cycles.
REQ-008 STOP_BITS  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 PARITY  input  3  000 none, 001 odd, 010 even, 011 mark (1), 100 space (0), 101..111 treated as none.
REQ-010 TX_EN  input  1  permits acceptance of new frames.
REQ-011 TXD  output  1  serial line, idle high.
REQ-012 TXB  output  1  busy; high while a frame is in progress.
REQ-013 FRAME_DONE  output  1  single-cycle pulse at frame completion.

Function
REQ-014 State machine SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-015 S_AXIS_TREADY SHALL be high only when state = IDLE, TX_EN = 1 and ARESET = 0, driven from registered state with no combinational path from TVALID.
REQ-016 Acceptance: when TVALID && TREADY at edge N, the sequencer SHALL latch TDATA, PR_DIV, STOP_BITS and PARITY and enter START at N+1.
REQ-017 Changes to PR_DIV/STOP_BITS/PARITY during a frame SHALL NOT affect that frame.
REQ-018 Each bit SHALL last exactly PR_DIV+1 cycles; PR_DIV = 0 yields 1-cycle bits; PR_DIV = 0xFFFF yields 65536-cycle bits (17-bit-safe counter, no wrap error).
REQ-019 TXD SHALL be registered: 0 in START, data bits LSB first in DATA, parity bit in PAR, 1 in STOP and IDLE.
REQ-020 DATA SHALL send exactly DATA_BITS bits, then go to PAR if parity mode is 001..100, otherwise directly to STOP.
REQ-021 Parity bit: odd -> XNOR-reduce of data bits; even -> XOR-reduce; mark -> 1; space -> 0.
REQ-022 STOP SHALL last one or two bit periods per latched STOP_BITS, then return to IDLE.
REQ-023 FRAME_DONE SHALL pulse high for exactly the last cycle of STOP.
REQ-024 TXB SHALL be high in every state except IDLE.
REQ-025 Minimum inter-frame gap: one IDLE cycle (TXD = 1) between the last stop cycle and the next start bit.
REQ-026 TX_EN deasserted mid-frame SHALL NOT abort the frame; it only blocks the next acceptance.
REQ-027 TVALID held low SHALL keep the sequencer in IDLE indefinitely, TXD = 1.

Reset
REQ-028 While ARESET = 1 at an edge: state IDLE, TXD = 1, TXB = 0, FRAME_DONE = 0, S_AXIS_TREADY = 0, bit and period counters zero.
REQ-029 ARESET asserted mid-frame SHALL abort the frame at that edge, with TXD = 1 from the next cycle; no FRAME_DONE SHALL be generated.
REQ-030 After ARESET deasserts, TREADY SHALL assert in the first cycle if TX_EN = 1.

Verification
REQ-031 PR_DIV = 3, PARITY = 000, STOP_BITS = 0, DATA_BITS = 8, send 0x55 -> TXD 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 total); FRAME_DONE in cycle 40; TREADY high again in cycle 41.
REQ-032 PARITY = 010 then 001, send 0x07 with PR_DIV = 1 -> parity bit 1 (even), 0 (odd); each frame 22 cycles.
REQ-033 STOP_BITS = 1, PARITY = 011, PR_DIV = 0, send 0xA0 -> 12-cycle frame, parity cycle = 1, two stop cycles = 1.
REQ-034 Back-to-back: TVALID held high with 0x01, 0x02, PR_DIV = 0 -> two 10-cycle frames separated by exactly one idle cycle; each byte accepted once.
REQ-035 Assert ARESET for 1 cycle in the 3rd data bit of a frame -> TXD = 1 next cycle, TXB = 0, no FRAME_DONE; a following 0x55 frame is correct.
REQ-036 Change PR_DIV from 3 to 7 and PARITY from 000 to 010 mid-frame, and drop TX_EN mid-frame -> current frame completes unchanged at 4 cycles/bit; TREADY stays low until TX_EN returns.
